// File: rtl/flag_write_sched.sv
// flag_write_sched: owns the flag register write port; init sweep, then round-robin insert/delete writes
//   ins_*/del_* : requester handshakes, ack is combinational and only in ready cycles
//   write_*     : registered write port to the flag register, held while ready_i = 0
//   init_done   : high while the sweep is complete and requests are being served
module flag_write_sched #(
  parameter int MAX_ADR_WIDTH = 10,
  parameter int ADR_WIDTH     = 10,
  parameter int BUCKET_SIZE   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready_i,
  input  logic                     clear_req,
  input  logic                     ins_req,
  input  logic [MAX_ADR_WIDTH-1:0] ins_adr,
  input  logic [BUCKET_SIZE-1:0]   ins_flags,
  output logic                     ins_ack,
  input  logic                     del_req,
  input  logic [MAX_ADR_WIDTH-1:0] del_adr,
  input  logic [BUCKET_SIZE-1:0]   del_flags,
  output logic                     del_ack,
  output logic [MAX_ADR_WIDTH-1:0] write_adr,
  output logic                     write_en,
  output logic [BUCKET_SIZE-1:0]   write_is_valid,
  output logic                     init_done
);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]             state_q, state_d;
  logic [ADR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   last_del_q, last_del_d;
  logic [MAX_ADR_WIDTH-1:0] write_adr_q, write_adr_d;
  logic                   write_en_q, write_en_d;
  logic [BUCKET_SIZE-1:0] write_is_valid_q, write_is_valid_d;
  logic                   serve, grant_ins, grant_del;
  always_comb begin
    serve            = state_q == RUN && ready_i && !clear_req;
    // on a tie the requester that did not win last time goes first
    grant_ins        = serve && ins_req && (!del_req || last_del_q);
    grant_del        = serve && del_req && (!ins_req || !last_del_q);
    state_d          = state_q;
    cnt_d            = cnt_q;
    last_del_d       = last_del_q;
    write_adr_d      = write_adr_q;
    write_en_d       = write_en_q;
    write_is_valid_d = write_is_valid_q;
    if (ready_i && state_q == INIT) begin
      write_en_d       = 1'b1;
      write_adr_d      = MAX_ADR_WIDTH'(cnt_q);
      write_is_valid_d = '0;
      cnt_d            = cnt_q + 1'b1;
      state_d          = &cnt_q ? RUN : INIT;
    end else if (ready_i) begin
      write_en_d       = grant_ins || grant_del;
      write_adr_d      = grant_ins ? ins_adr : grant_del ? del_adr : write_adr_q;
      write_is_valid_d = grant_ins ? ins_flags : grant_del ? del_flags : write_is_valid_q;
      last_del_d       = grant_ins ? 1'b0 : grant_del ? 1'b1 : last_del_q;
      state_d          = clear_req ? INIT : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= INIT;
      cnt_q            <= '0;
      last_del_q       <= 1'b1;
      write_adr_q      <= '0;
      write_en_q       <= 1'b0;
      write_is_valid_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      last_del_q       <= last_del_d;
      write_adr_q      <= write_adr_d;
      write_en_q       <= write_en_d;
      write_is_valid_q <= write_is_valid_d;
    end
  end
  assign ins_ack        = !reset && grant_ins;
  assign del_ack        = !reset && grant_del;
  assign write_adr      = write_adr_q;
  assign write_en       = write_en_q;
  assign write_is_valid = write_is_valid_q;
  assign init_done      = state_q == RUN;
endmodule
